// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: NOP encoding, exception codes
// and the per-edge action decoded by each inter-stage register.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h0000_4180;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [2:0] {
        RST,
        REQ,
        FLUSH,
        ADV,
        HOLD
    } stage_act_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of
// wrapping so a long stall never reads back as zero.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (F/D, D/E, E/M, M/W) with stall, flush and
// exception-entry redirect, plus a saturating consecutive-stall counter.
module pipe_stage_reg
    import cpu_pkg::*;
#(
    parameter int                INSTR_W    = 32,
    parameter int                PC_W       = 32,
    parameter int                EXC_W      = 5,
    parameter logic [PC_W-1:0]   HANDLER_PC = PC_W'(DEFAULT_HANDLER_PC),
    parameter int                CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               flush,
    input  logic               req,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    PC_in,
    input  logic [EXC_W-1:0]   exc_in,
    input  logic               bd_in,
    input  logic               valid_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    PC_out,
    output logic [EXC_W-1:0]   exc_out,
    output logic               bd_out,
    output logic               valid_out,
    output logic [CNT_W-1:0]   stall_cnt
);

    stage_act_e act;

    always_comb begin
        act = HOLD;
        if (reset)      act = RST;
        else if (req)   act = REQ;
        else if (flush) act = FLUSH;
        else if (en)    act = ADV;
    end

    // PC keeps tracking the input on reset/flush so EPC taken from a bubble is right.
    always_ff @(posedge clk) begin
        case (act)
            RST: begin
                instr_out <= INSTR_W'(NOP_INSTR);
                PC_out    <= PC_in;
                exc_out   <= '0;
                bd_out    <= 1'b0;
                valid_out <= 1'b0;
            end
            REQ: begin
                instr_out <= INSTR_W'(NOP_INSTR);
                PC_out    <= HANDLER_PC;
                exc_out   <= '0;
                bd_out    <= 1'b0;
                valid_out <= 1'b0;
            end
            FLUSH: begin
                instr_out <= INSTR_W'(NOP_INSTR);
                PC_out    <= PC_in;
                exc_out   <= '0;
                bd_out    <= bd_in;
                valid_out <= 1'b0;
            end
            ADV: begin
                instr_out <= instr_in;
                PC_out    <= PC_in;
                exc_out   <= exc_in;
                bd_out    <= bd_in;
                valid_out <= valid_in;
            end
            default: ;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (act != HOLD),
        .inc   (act == HOLD),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a behavioural model pushes expected outputs when stimulus
// is driven; they are popped and compared one edge later.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, en, flush, req, bd_in, valid_in;
    logic [31:0] instr_in, PC_in;
    logic [4:0]  exc_in;
    logic [31:0] instr_out, PC_out, instr_out2, PC_out2;
    logic [4:0]  exc_out, exc_out2;
    logic        bd_out, valid_out, bd_out2, valid_out2;
    logic [7:0]  stall_cnt;
    logic [1:0]  stall_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .req(req),
        .instr_in(instr_in), .PC_in(PC_in), .exc_in(exc_in), .bd_in(bd_in),
        .valid_in(valid_in), .instr_out(instr_out), .PC_out(PC_out),
        .exc_out(exc_out), .bd_out(bd_out), .valid_out(valid_out),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .req(req),
        .instr_in(instr_in), .PC_in(PC_in), .exc_in(exc_in), .bd_in(bd_in),
        .valid_in(valid_in), .instr_out(instr_out2), .PC_out(PC_out2),
        .exc_out(exc_out2), .bd_out(bd_out2), .valid_out(valid_out2),
        .stall_cnt(stall_cnt2)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
        logic [7:0]  cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t q[$];
    exp_t m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one edge worth of stimulus, advance the model, compare after the edge.
    task automatic step(input logic r, input logic rq, input logic fl, input logic e,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [4:0] exc, input logic bd, input logic v);
        exp_t x;
        reset = r; req = rq; flush = fl; en = e;
        instr_in = ins; PC_in = pc; exc_in = exc; bd_in = bd; valid_in = v;
        if (r) begin
            m.instr = 0; m.pc = pc; m.exc = 0; m.bd = 0; m.valid = 0; m.cnt = 0; m.cnt2 = 0;
        end else if (rq) begin
            m.instr = 0; m.pc = 32'h0000_4180; m.exc = 0; m.bd = 0; m.valid = 0; m.cnt = 0; m.cnt2 = 0;
        end else if (fl) begin
            m.instr = 0; m.pc = pc; m.exc = 0; m.bd = bd; m.valid = 0; m.cnt = 0; m.cnt2 = 0;
        end else if (e) begin
            m.instr = ins; m.pc = pc; m.exc = exc; m.bd = bd; m.valid = v; m.cnt = 0; m.cnt2 = 0;
        end else begin
            if (m.cnt != 8'hFF) m.cnt = m.cnt + 8'd1;
            if (m.cnt2 != 2'd3) m.cnt2 = m.cnt2 + 2'd1;
        end
        q.push_back(m);
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk("instr_out", 64'(instr_out), 64'(x.instr));
        chk("PC_out",    64'(PC_out),    64'(x.pc));
        chk("exc_out",   64'(exc_out),   64'(x.exc));
        chk("bd_out",    64'(bd_out),    64'(x.bd));
        chk("valid_out", 64'(valid_out), 64'(x.valid));
        chk("stall_cnt", 64'(stall_cnt), 64'(x.cnt));
        chk("stall_cnt_w2", 64'(stall_cnt2), 64'(x.cnt2));
        chk("PC_out_w2", 64'(PC_out2), 64'(x.pc));
    endtask

    initial begin
        m = '0;
        reset = 0; req = 0; flush = 0; en = 0;
        instr_in = 0; PC_in = 0; exc_in = 0; bd_in = 0; valid_in = 0;
        #1;

        // reset state
        step(1, 0, 0, 0, 32'hDEAD_BEEF, 32'h3000, 5'd4, 1, 1);
        chk("rst_pc_const", 64'(PC_out), 64'h3000);

        // load, then stall 3 edges, then load new
        step(0, 0, 0, 1, 32'h2408_0005, 32'h3004, 5'd0, 1, 1);
        chk("adv_instr_const", 64'(instr_out), 64'h2408_0005);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 32'h1111_1111, 32'h3008, 5'd10, 0, 0);
        chk("stall3_const", 64'(stall_cnt), 64'd3);
        step(0, 0, 0, 1, 32'h0000_0020, 32'h3008, 5'd12, 0, 1);

        // 2-bit counter saturation (6 holds) and 8-bit saturation
        for (int i = 0; i < 6; i++)
            step(0, 0, 0, 0, 32'h0, 32'h3ABC, 5'd0, 1, 1);
        chk("sat2_const", 64'(stall_cnt2), 64'd3);
        for (int i = 0; i < 260; i++)
            step(0, 0, 0, 0, 32'h0, 32'h3ABC, 5'd0, 1, 1);
        chk("sat8_const", 64'(stall_cnt), 64'd255);

        // flush during stall keeps PC and bd
        step(0, 0, 1, 0, 32'h2408_0005, 32'h3010, 5'd5, 1, 1);

        // valid_in=0 passthrough with exception code captured verbatim
        step(0, 0, 0, 1, 32'h0123_4567, 32'h3014, 5'd4, 0, 0);

        // req beats flush and en
        step(0, 1, 1, 1, 32'h2408_0005, 32'h3018, 5'd12, 1, 1);
        chk("req_pc_const", 64'(PC_out), 64'h4180);
        // req while stalled
        step(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
        step(0, 1, 0, 0, 32'h0, 32'h301C, 5'd0, 1, 1);

        // reset beats req; reset mid-stall then normal load
        step(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
        step(1, 1, 0, 0, 32'h5555_AAAA, 32'h3020, 5'd12, 1, 1);
        chk("rst_req_pc_const", 64'(PC_out), 64'h3020);
        step(0, 0, 0, 1, 32'h8C08_0000, 32'h3024, 5'd0, 0, 1);

        // random mix
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) != 0),
                 $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic inter-stage pipeline register for the 5-stage MIPS core; one instance per stage boundary (F/D, D/E, E/M, M/W).
- Carries instruction, PC, exception code, branch-delay flag and a valid bit.
- Supports stall (hold), flush (bubble with PC kept), and exception-entry redirect (bubble with handler PC).
- Contains a saturating stall-cycle counter for hazard-unit debug and performance visibility.

Parameters:
- INSTR_W, 32, instruction field width
- PC_W, 32, PC field width
- EXC_W, 5, exception code width (ExcCode)
- HANDLER_PC, 32'h0000_4180, PC loaded on exception-entry request
- CNT_W, 8, stall counter width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- en  input  1  1 = advance stage, 0 = hold (stall)
- flush  input  1  insert bubble this cycle, PC preserved
- req  input  1  exception/interrupt entry: insert bubble, redirect PC to HANDLER_PC
- instr_in  input  INSTR_W  upstream instruction
- PC_in  input  PC_W  upstream PC
- exc_in  input  EXC_W  upstream exception code, 0 = none
- bd_in  input  1  upstream instruction is in a delay slot
- valid_in  input  1  upstream slot holds a real instruction
- instr_out  output  INSTR_W  registered instruction
- PC_out  output  PC_W  registered PC
- exc_out  output  EXC_W  registered exception code
- bd_out  output  1  registered delay-slot flag
- valid_out  output  1  registered valid
- stall_cnt  output  CNT_W  consecutive hold cycles, saturating

Behaviour:
- One clock, clk. reset is synchronous and active-high. All state updates on the rising edge of clk.
- Priority per edge: reset > req > flush > en > hold. Exactly one action per edge.
- reset:
  - instr_out=0 (NOP), PC_out<=PC_in (PC tracks input, as with the existing stage registers), exc_out=0, bd_out=0, valid_out=0, stall_cnt=0.
- req:
  - instr_out=0, PC_out<=HANDLER_PC, exc_out=0, bd_out=0, valid_out=0, stall_cnt=0.
  - Overrides en=0; a stalled stage is still redirected.
- flush:
  - instr_out=0, exc_out=0, valid_out=0.
  - PC_out<=PC_in and bd_out<=bd_in, so a later EPC taken from a bubble is correct.
  - stall_cnt=0. Overrides en=0.
- en=1, no higher-priority event:
  - instr_out<=instr_in, PC_out<=PC_in, exc_out<=exc_in, bd_out<=bd_in, valid_out<=valid_in, stall_cnt=0.
- hold (en=0, no reset/req/flush):
  - All payload outputs and valid_out keep their values.
  - stall_cnt<=stall_cnt+1, saturating at 2^CNT_W-1; it must never wrap to 0.
- Latency:
  - Every output reflects the inputs sampled at the previous edge (1 cycle).
  - No combinational path from any input to any output.
- valid_in=0 with en=1 is passed through unchanged. The payload is still captured; downstream ignores it.
- exc_out is captured verbatim; no merging or masking.
- Reset mid-stall: the stall counter clears and the bubble is loaded; the next edge with en=1 loads normally.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INSTR=32'h0, DEFAULT_HANDLER_PC=32'h0000_4180.
  - ExcCode constants: EXC_NONE=0, EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12.
  - Stage-action enum: RST, REQ, FLUSH, ADV, HOLD.
- One sub-module, sat_counter (parameter W; ports clk, reset, clr, inc, cnt), used for stall_cnt.
- The priority decode stays in pipe_stage_reg.

Test Plan:
- Reset with PC_in=32'h3000 -> instr_out=0, PC_out=32'h3000, exc_out=0, bd_out=0, valid_out=0, stall_cnt=0.
- en=1, instr_in=32'h2408_0005, PC_in=32'h3004, exc_in=0, bd_in=1, valid_in=1 -> outputs equal these values one edge later.
- en=0 for 3 edges after loading 32'h2408_0005 -> outputs held, stall_cnt=1,2,3; then en=1 -> new payload loaded, stall_cnt=0.
- CNT_W=2, en=0 for 6 edges -> stall_cnt sequence 1,2,3,3,3,3 (no wrap).
- flush=1, en=0, PC_in=32'h3010, bd_in=1 -> instr_out=0, PC_out=32'h3010, bd_out=1, valid_out=0, exc_out=0.
- req=1, flush=1, en=1, exc_in=5'd12 -> PC_out=32'h4180, instr_out=0, exc_out=0, valid_out=0. Also check reset=1 together with req=1 -> PC_out=PC_in.
